osc_baud_sched: RTL and testbench

Baud-timing scheduler driven by the on-chip oscillator clock. It holds the UART timing logic off until the oscillator has settled, then generates the 16x oversample tick and the 1x bit tick from a fractional phase accumulator. Divisor changes are taken through a valid/ready handshake and applied only on bit boundaries. It sits between the oscillator wrapper and the UART TX/RX engines, and is the only source of their timing enables.

---
 rtl/osc_baud_sched.sv | 130 +++++++++++++
 tb/tb_osc_baud_sched.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/osc_baud_sched.sv
// Baud scheduler: waits out oscillator warm-up, then derives 16x oversample and bit ticks
// from a fractional phase accumulator; divisor updates land only on bit boundaries.
module osc_baud_sched #(
    parameter int unsigned      ACC_W         = 16,
    parameter int unsigned      WARMUP_CYCLES = 1024,
    parameter logic [ACC_W-1:0] DEFAULT_INC   = 16'd1208
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             locked,
    output logic             running,
    output logic             os_tick,
    output logic             bit_tick
);

    localparam logic [1:0] StWarmup = 2'd0;
    localparam logic [1:0] StIdle   = 2'd1;
    localparam logic [1:0] StRun    = 2'd2;

    localparam int unsigned       WCNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  inc_q, inc_d;
    logic [ACC_W-1:0]  pend_inc_q, pend_inc_d;
    logic [3:0]        os_cnt_q, os_cnt_d;
    logic              pend_q, pend_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic [ACC_W:0]    sum;
    logic              cfg_fire;

    assign sum       = {1'b0, acc_q} + {1'b0, inc_q};
    assign cfg_ready = (state_q == StIdle) || ((state_q == StRun) && !pend_q);
    assign cfg_fire  = cfg_valid && cfg_ready;
    // Warm-up is only ever re-entered through rst, so this is sticky.
    assign locked    = (state_q != StWarmup);
    assign running   = (state_q == StRun);
    assign os_tick   = os_tick_q;
    assign bit_tick  = bit_tick_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        acc_d      = acc_q;
        inc_d      = inc_q;
        pend_inc_d = pend_inc_q;
        os_cnt_d   = os_cnt_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        case (state_q)
            StWarmup: begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = StIdle;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (cfg_fire) begin
                    inc_d = cfg_inc;
                end
                if (enable) begin
                    state_d  = StRun;
                    acc_d    = '0;
                    os_cnt_d = '0;
                end
            end
            StRun: begin
                if (!enable) begin
                    // Leaving RUN: acc/os_cnt freeze, a waiting divisor is applied now.
                    state_d = StIdle;
                    pend_d  = 1'b0;
                    if (cfg_fire) begin
                        inc_d = cfg_inc;
                    end else if (pend_q) begin
                        inc_d = pend_inc_q;
                    end
                end else begin
                    acc_d     = sum[ACC_W-1:0];
                    os_tick_d = sum[ACC_W];
                    if (sum[ACC_W]) begin
                        os_cnt_d   = os_cnt_q + 4'd1;
                        bit_tick_d = (os_cnt_q == 4'd15);
                    end
                    if (bit_tick_q && pend_q) begin
                        inc_d  = pend_inc_q;
                        pend_d = 1'b0;
                    end else if (cfg_fire) begin
                        pend_inc_d = cfg_inc;
                        pend_d     = 1'b1;
                    end
                end
            end
            default: state_d = StWarmup;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWarmup;
            wcnt_q     <= '0;
            acc_q      <= '0;
            inc_q      <= DEFAULT_INC;
            pend_inc_q <= '0;
            os_cnt_q   <= '0;
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_inc_q <= pend_inc_d;
            os_cnt_q   <= os_cnt_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

endmodule

// File: tb/tb_osc_baud_sched.sv
// Directed bench for osc_baud_sched with ACC_W=8, WARMUP_CYCLES=8, DEFAULT_INC=128.
module tb_osc_baud_sched;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] cfg_inc;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       locked;
    logic       running;
    logic       os_tick;
    logic       bit_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int n_os;
    int n_bit;
    int first_k;
    logic exp_os;
    logic exp_bit;
    logic exp_rdy;

    osc_baud_sched #(
        .ACC_W        (8),
        .WARMUP_CYCLES(8),
        .DEFAULT_INC  (8'd128)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg_inc  (cfg_inc),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .locked   (locked),
        .running  (running),
        .os_tick  (os_tick),
        .bit_tick (bit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called one cycle into reset; releases rst and walks the 8-cycle warm-up into RUN.
    task automatic warmup_seq();
        rst = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            chk("warm_locked", locked, 0);
            chk("warm_quiet", {running, os_tick, bit_tick, cfg_ready}, 0);
        end
        step();
        chk("lock_edge", locked, 1);
        chk("idle_ready", cfg_ready, 1);
        chk("idle_not_running", running, 0);
        step();
        chk("run_entry", running, 1);
        chk("run_entry_quiet", {os_tick, bit_tick}, 0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        cfg_inc   = 8'd0;
        step();
        step();
        chk("reset_outputs", {cfg_ready, locked, running, os_tick, bit_tick}, 0);

        warmup_seq();

        // Default inc=128: os_tick every 2 cycles from offset 2, bit_tick every 32.
        for (int k = 0; k <= 64; k++) begin
            exp_os  = (k >= 2) && (k % 2 == 0);
            exp_bit = (k > 0) && (k % 32 == 0);
            chk("rate_os", os_tick, exp_os);
            chk("rate_bit", bit_tick, exp_bit);
            if (k == 64) enable = 1'b0;
            step();
        end
        chk("drop_running", running, 0);
        chk("drop_quiet", {os_tick, bit_tick}, 0);
        chk("drop_ready", cfg_ready, 1);

        // Handshake and enable in the same IDLE cycle: RUN starts with inc=3.
        cfg_valid = 1'b1;
        cfg_inc   = 8'd3;
        enable    = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("frac_entry", {running, os_tick}, 2'b10);
        n_os    = 0;
        n_bit   = 0;
        first_k = 0;
        for (int k = 1; k <= 1024; k++) begin
            step();
            if (os_tick) begin
                n_os++;
                if (first_k == 0) first_k = k;
            end
            if (bit_tick) n_bit++;
        end
        chk("frac_count", n_os, 12);
        chk("frac_first", first_k, 86);
        chk("frac_bits", n_bit, 0);
        // Leave acc at a nonzero phase (3*1030 mod 256 = 18) before pausing.
        for (int k = 1025; k <= 1030; k++) step();

        // Pause 50 cycles; load inc=16 while idle.
        enable = 1'b0;
        step();
        for (int i = 0; i < 50; i++) begin
            chk("pause_quiet", {running, os_tick, bit_tick}, 0);
            if (i == 10) begin
                chk("pause_ready", cfg_ready, 1);
                cfg_valid = 1'b1;
                cfg_inc   = 8'd16;
            end else begin
                cfg_valid = 1'b0;
            end
            if (i == 49) enable = 1'b1;
            step();
        end
        chk("resume_running", running, 1);

        // Resume from cleared acc/os_cnt at inc=16; request inc=64 mid-bit at offset 100.
        for (int k = 0; k <= 300; k++) begin
            exp_os  = (k >= 16 && k <= 256 && k % 16 == 0) || (k >= 261 && (k - 261) % 4 == 0);
            exp_bit = (k == 256);
            exp_rdy = (k <= 100) || (k >= 257);
            chk("recfg_os", os_tick, exp_os);
            chk("recfg_bit", bit_tick, exp_bit);
            chk("recfg_ready", cfg_ready, exp_rdy);
            cfg_valid = (k == 100) || (k == 300);
            cfg_inc   = (k == 300) ? 8'd1 : 8'd64;
            step();
        end
        cfg_valid = 1'b0;
        chk("pend_ready_low", cfg_ready, 0);

        // Reset with an update pending: it must be discarded, inc back to 128.
        rst = 1'b1;
        step();
        chk("rst_outputs", {cfg_ready, locked, running, os_tick, bit_tick}, 0);
        warmup_seq();
        step();
        chk("post_rst_k1", os_tick, 0);
        step();
        chk("post_rst_k2", os_tick, 1);
        step();
        chk("post_rst_k3", os_tick, 0);
        step();
        chk("post_rst_k4", os_tick, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
